paddle_ctl: RTL and testbench
=============================

Name: paddle_ctl

Overview:
- Produces the paddle vertical position `y_pos` that the paddle-drawing stage directly downstream consumes.
- Samples asynchronous up/down buttons and updates position once per frame, on the rising edge of vertical blank, so the paddle never tears mid-frame.
- Accelerates while a direction is held and saturates at the screen edges.

Parameters:
- SCREEN_H, 768, visible lines.
- PADDLE_H, 80, paddle height in lines.
- Y_INIT, 344, reset/centre position, (SCREEN_H-PADDLE_H)/2.
- SPEED_MIN, 2, lines per frame at start of a move.
- SPEED_MAX, 8, speed ceiling.
- ACCEL_FRAMES, 4, consecutive same-direction frames per +1 speed step.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vblnk_in  in  1  vertical blank from timing chain, pclk domain
- btn_up  in  1  asynchronous button, active high
- btn_down  in  1  asynchronous button, active high
- y_pos  out  12  paddle top line, range 0..Y_MAX
- moving  out  1  state != IDLE
- at_top  out  1  y_pos == 0
- at_bottom  out  1  y_pos == Y_MAX

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock pclk.
- Reset values:
  - y_pos = Y_INIT; moving = 0; at_top = 0; at_bottom = 0.
  - state = IDLE; speed = SPEED_MIN; cnt = 0.
  - Synchronizer flops = 0; vblnk_d = 0.
- Y_MAX = SCREEN_H - PADDLE_H = 688.
- Button synchronizers: two-flop per button. Decisions use only the second-stage outputs up_s/down_s.
- Frame tick:
  - vblnk_d <= vblnk_in every cycle; tick = vblnk_in & ~vblnk_d.
  - vblnk held high produces exactly one tick.
- All state, y_pos and flag updates occur only on a clock edge where tick=1; otherwise everything holds.
- dir at tick:
  - UP if up_s & ~down_s.
  - DOWN if down_s & ~up_s.
  - NONE otherwise, including both pressed.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN.
  - dir = NONE: state <= IDLE, speed <= SPEED_MIN, cnt <= 0, y holds.
  - dir differs from current state (from IDLE or a reversal): state <= dir, step = SPEED_MIN, speed <= SPEED_MIN, cnt <= 1.
  - dir same as state: step = speed.
    - If cnt == ACCEL_FRAMES-1: cnt <= 0, speed <= min(speed+1, SPEED_MAX).
    - Else cnt <= cnt+1.
- Arithmetic:
  - Compute in 13-bit signed: next = y ± step.
  - If next < 0: y <= 0. If next > Y_MAX: y <= Y_MAX.
  - On a saturation, speed <= SPEED_MIN and cnt <= 0; state unchanged.
  - No wrap-around ever.
- Flags: at_top, at_bottom and moving are registered from the new y/state in the same edge as y_pos, never lagging it.
- Latency:
  - y_pos changes on the edge where vblnk_in is first sampled high.
  - A button edge needs 2 pclk cycles to reach up_s/down_s before it can be seen at a tick.
  - Presses that begin and end between ticks are ignored.
- rst asserted mid-move: next edge forces reset values regardless of tick. The first tick after release starts again from SPEED_MIN.

Test Plan:
- Reset: rst for 3 cycles, no buttons, 3 vblank pulses -> y_pos=344, moving=0, at_top=at_bottom=0 throughout.
- Acceleration: btn_down held, 9 vblank pulses -> y_pos sequence 346,348,350,352,355,358,361,364,368; moving=1 from first tick.
- Top clamp: btn_up held, pulse vblank until y_pos stops -> y_pos reaches 0 exactly, at_top=1, never shows 4095 or any value >688; next up frame moves 0 lines.
- Reversal / both pressed: accelerate down to speed 4, then btn_up -> first step up exactly 2. Both buttons at a tick -> y holds, moving=0; following down-only tick steps 2.
- Tick edge cases:
  - vblnk_in held high 1000 cycles with btn_down -> single 2-line step.
  - Button pulse of 5 pclk between vblanks -> no movement.
  - Button asserted 1 cycle before vblnk rise -> ignored (synchronizer latency).
- Mid-motion reset: while moving down at speed 5, assert rst for 1 cycle -> y_pos=344 next edge, moving=0; next down tick -> 346.

Source files
------------

// File: rtl/paddle_ctl_if.sv
// Paddle control bundle: frame timing and button inputs in, paddle position and status out.
interface paddle_ctl_if;
  logic        vblnk_in;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] y_pos;
  logic        moving;
  logic        at_top;
  logic        at_bottom;

  modport master (
    output vblnk_in, btn_up, btn_down,
    input  y_pos, moving, at_top, at_bottom
  );

  modport slave (
    input  vblnk_in, btn_up, btn_down,
    output y_pos, moving, at_top, at_bottom
  );
endinterface

// File: rtl/paddle_ctl.sv
// Paddle vertical position: buttons sampled once per frame at vblank rise, accelerating, clamped at screen edges.
// Outputs update on the edge vblnk_in is first seen high; no backpressure, downstream consumes y_pos directly.
module paddle_ctl #(
  parameter int SCREEN_H     = 768,
  parameter int PADDLE_H     = 80,
  parameter int Y_INIT       = 344,
  parameter int SPEED_MIN    = 2,
  parameter int SPEED_MAX    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input logic         pclk,
  input logic         rst,
  paddle_ctl_if.slave bus
);

  localparam int Y_MAX = SCREEN_H - PADDLE_H;
  localparam int SPD_W = $clog2(SPEED_MAX + 1);
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [SPD_W-1:0]  SPD_MIN  = SPD_W'(SPEED_MIN);
  localparam logic [SPD_W-1:0]  SPD_MAX  = SPD_W'(SPEED_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [11:0]       Y_MAX_V  = 12'(Y_MAX);
  localparam logic [11:0]       Y_INIT_V = 12'(Y_INIT);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

  logic up_m, up_s, down_m, down_s, vblnk_d, tick;
  state_t           state, state_nxt, dir;
  logic [SPD_W-1:0] speed, speed_nxt, step;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [11:0]      y, y_nxt;
  logic signed [12:0] y_ext, step_ext, y_calc;
  logic moving_q, at_top_q, at_bottom_q;
  logic moving_nxt, at_top_nxt, at_bottom_nxt;

  assign tick = bus.vblnk_in & ~vblnk_d;

  always_ff @(posedge pclk) begin
    if (rst) begin
      up_m        <= 1'b0;
      up_s        <= 1'b0;
      down_m      <= 1'b0;
      down_s      <= 1'b0;
      vblnk_d     <= 1'b0;
      state       <= IDLE;
      speed       <= SPD_MIN;
      cnt         <= '0;
      y           <= Y_INIT_V;
      moving_q    <= 1'b0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
    end else begin
      up_m        <= bus.btn_up;
      up_s        <= up_m;
      down_m      <= bus.btn_down;
      down_s      <= down_m;
      vblnk_d     <= bus.vblnk_in;
      state       <= state_nxt;
      speed       <= speed_nxt;
      cnt         <= cnt_nxt;
      y           <= y_nxt;
      moving_q    <= moving_nxt;
      at_top_q    <= at_top_nxt;
      at_bottom_q <= at_bottom_nxt;
    end
  end

  always_comb begin
    dir       = IDLE;
    state_nxt = state;
    speed_nxt = speed;
    cnt_nxt   = cnt;
    step      = '0;
    y_nxt     = y;
    y_ext     = {1'b0, y};
    step_ext  = 13'sd0;
    y_calc    = 13'sd0;
    if (up_s & ~down_s) begin
      dir = MOVE_UP;
    end else if (down_s & ~up_s) begin
      dir = MOVE_DOWN;
    end
    if (tick) begin
      if (dir == IDLE) begin
        state_nxt = IDLE;
        speed_nxt = SPD_MIN;
        cnt_nxt   = '0;
      end else if (dir != state) begin
        // New move or reversal always restarts from the slowest speed.
        state_nxt = dir;
        step      = SPD_MIN;
        speed_nxt = SPD_MIN;
        cnt_nxt   = CNT_ONE;
      end else begin
        step = speed;
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          speed_nxt = (speed >= SPD_MAX) ? SPD_MAX : speed + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      if (dir != IDLE) begin
        step_ext = {{(13-SPD_W){1'b0}}, step};
        y_calc   = (dir == MOVE_UP) ? y_ext - step_ext : y_ext + step_ext;
        if (y_calc[12]) begin
          y_nxt     = '0;
          speed_nxt = SPD_MIN;
          cnt_nxt   = '0;
        end else if (y_calc > Y_MAX_S) begin
          y_nxt     = Y_MAX_V;
          speed_nxt = SPD_MIN;
          cnt_nxt   = '0;
        end else begin
          y_nxt = y_calc[11:0];
        end
      end
    end
  end

  // Flags derive from the post-update values so they never lag y_pos.
  always_comb begin
    moving_nxt    = (state_nxt != IDLE);
    at_top_nxt    = (y_nxt == 12'd0);
    at_bottom_nxt = (y_nxt == Y_MAX_V);
  end

  assign bus.y_pos     = y;
  assign bus.moving    = moving_q;
  assign bus.at_top    = at_top_q;
  assign bus.at_bottom = at_bottom_q;

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed bench for paddle_ctl: vector table for frame-by-frame motion plus hand sequences for clamps and timing corners.
module tb_paddle_ctl;
  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  paddle_ctl_if bus();
  paddle_ctl dut (.pclk(pclk), .rst(rst), .bus(bus.slave));

  typedef struct {
    bit          up;
    bit          down;
    logic [11:0] y;
    bit          mv;
    bit          top;
    bit          bot;
  } vec_t;

  vec_t vt[17];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [11:0] ey, input bit em, input bit et, input bit eb);
    tests++;
    if ({bus.y_pos, bus.moving, bus.at_top, bus.at_bottom} !== {ey, em, et, eb}) begin
      fails++;
      $display("FAIL %s: got y=%0d mv=%0b top=%0b bot=%0b, want y=%0d mv=%0b top=%0b bot=%0b",
               name, bus.y_pos, bus.moving, bus.at_top, bus.at_bottom, ey, em, et, eb);
    end
  endtask

  // Set buttons, let them cross the synchronizer, then raise vblank for 'hold' cycles.
  task automatic frame(input bit up, input bit dn, input int hold);
    @(negedge pclk);
    bus.btn_up   = up;
    bus.btn_down = dn;
    repeat (3) @(negedge pclk);
    bus.vblnk_in = 1'b1;
    repeat (hold) @(negedge pclk);
    bus.vblnk_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    logic [11:0] prev;
    bit          stopped;

    vt[0]  = '{0, 0, 12'd344, 0, 0, 0};
    vt[1]  = '{0, 0, 12'd344, 0, 0, 0};
    vt[2]  = '{0, 0, 12'd344, 0, 0, 0};
    vt[3]  = '{0, 1, 12'd346, 1, 0, 0};
    vt[4]  = '{0, 1, 12'd348, 1, 0, 0};
    vt[5]  = '{0, 1, 12'd350, 1, 0, 0};
    vt[6]  = '{0, 1, 12'd352, 1, 0, 0};
    vt[7]  = '{0, 1, 12'd355, 1, 0, 0};
    vt[8]  = '{0, 1, 12'd358, 1, 0, 0};
    vt[9]  = '{0, 1, 12'd361, 1, 0, 0};
    vt[10] = '{0, 1, 12'd364, 1, 0, 0};
    vt[11] = '{0, 1, 12'd368, 1, 0, 0};
    vt[12] = '{1, 0, 12'd366, 1, 0, 0};
    vt[13] = '{1, 0, 12'd364, 1, 0, 0};
    vt[14] = '{1, 1, 12'd364, 0, 0, 0};
    vt[15] = '{0, 1, 12'd366, 1, 0, 0};
    vt[16] = '{0, 0, 12'd366, 0, 0, 0};

    bus.vblnk_in = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    check("reset", 12'd344, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      frame(vt[i].up, vt[i].down, 1);
      check($sformatf("vec%0d", i), vt[i].y, vt[i].mv, vt[i].top, vt[i].bot);
    end

    stopped = 1'b0;
    for (int k = 0; k < 200 && !stopped; k++) begin
      prev = bus.y_pos;
      frame(1, 0, 1);
      tests++;
      if (bus.y_pos > 12'd688) begin
        fails++;
        $display("FAIL up_range: got y=%0d, want <= 688", bus.y_pos);
      end
      if (bus.y_pos == prev) stopped = 1'b1;
    end
    tests++;
    if (!stopped) begin
      fails++;
      $display("FAIL up_stop: y=%0d still moving after 200 frames, want stop", bus.y_pos);
    end
    check("top_clamp", 12'd0, 1, 1, 0);
    frame(1, 0, 1);
    check("top_hold", 12'd0, 1, 1, 0);

    stopped = 1'b0;
    for (int k = 0; k < 200 && !stopped; k++) begin
      prev = bus.y_pos;
      frame(0, 1, 1);
      tests++;
      if (bus.y_pos > 12'd688) begin
        fails++;
        $display("FAIL down_range: got y=%0d, want <= 688", bus.y_pos);
      end
      if (bus.y_pos == prev) stopped = 1'b1;
    end
    check("bot_clamp", 12'd688, 1, 0, 1);
    frame(0, 0, 1);
    check("bot_idle", 12'd688, 0, 0, 1);

    for (int k = 0; k < 3; k++) begin
      frame(1, 0, 1);
      check($sformatf("leave_bot%0d", k), 12'(688 - 2 * (k + 1)), 1, 0, 0);
    end
    frame(0, 0, 1);
    check("idle_682", 12'd682, 0, 0, 0);

    frame(0, 1, 1000);
    check("vblank_held", 12'd684, 1, 0, 0);
    frame(0, 0, 1);
    check("idle_684", 12'd684, 0, 0, 0);

    @(negedge pclk);
    bus.btn_down = 1'b1;
    repeat (5) @(negedge pclk);
    bus.btn_down = 1'b0;
    repeat (4) @(negedge pclk);
    frame(0, 0, 1);
    check("short_press", 12'd684, 0, 0, 0);

    @(negedge pclk);
    bus.btn_down = 1'b1;
    @(negedge pclk);
    bus.vblnk_in = 1'b1;
    repeat (2) @(negedge pclk);
    bus.vblnk_in = 1'b0;
    bus.btn_down = 1'b0;
    repeat (3) @(negedge pclk);
    check("late_press", 12'd684, 0, 0, 0);

    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    check("rerun_reset", 12'd344, 0, 0, 0);
    for (int k = 0; k < 12; k++) frame(0, 1, 1);
    check("speed5_pos", 12'd380, 1, 0, 0);
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check("mid_reset", 12'd344, 0, 0, 0);
    rst = 1'b0;
    frame(0, 1, 1);
    check("after_reset", 12'd346, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
